// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared fetch/data memory port arbiter with starvation guard; MEM_ARB_STATS_EN enables perf counters
module mem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              if_stall,
  output logic              d_stall,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              halted,
  output logic [15:0]       stat_if,
  output logic [15:0]       stat_d,
  output logic [15:0]       stat_conf
);

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        halted_q, halted_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic if_live;
  logic fetch_pri;
  logic d_win;
  logic d_gnt;
  logic if_gnt;
  logic is_ecall;

  // Upper address bits are beyond the memory block and intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

  // Grant decision: data wins unless fetch has starved long enough; nothing is granted during reset.
  always_comb begin
    if_live   = if_req & ~halted_q;
    fetch_pri = (starve_cnt_q == LIMIT_C);
    d_win     = d_req & ~(fetch_pri & if_live);
    d_gnt     = ~rst & d_win;
    if_gnt    = ~rst & if_live & ~d_win;
    if_stall  = ~rst & if_req & ~if_gnt;
    d_stall   = ~rst & d_req & ~d_gnt;
  end

  // Shared port mux driven by whichever requester holds the grant.
  always_comb begin
    mem_addr   = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = 3'b000;
    mem_wdata  = 32'h0;
    if (d_gnt) begin
      mem_addr   = d_addr[ADDR_W-1:0];
      mem_read   = ~d_we;
      mem_write  = d_we;
      mem_funct3 = d_funct3;
      mem_wdata  = d_wdata;
    end else if (if_gnt) begin
      mem_addr   = if_addr[ADDR_W-1:0];
      mem_read   = 1'b1;
      mem_funct3 = 3'b010;
    end
  end

  assign is_ecall = (mem_rdata[6:2] == 5'b11100) && !mem_rdata[20];

  // Next-state for starvation counter, halt flag and registered responses.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt || !if_req) begin
      starve_cnt_d = '0;
    end else if (if_live && (starve_cnt_q != LIMIT_C)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    halted_d   = halted_q | (if_gnt & is_ecall);
    if_valid_d = if_gnt;
    if_rdata_d = if_gnt ? mem_rdata : if_rdata_q;
    d_valid_d  = d_gnt;
    d_rdata_d  = (d_gnt && !d_we) ? mem_rdata : d_rdata_q;
  end

  // State and response registers; reset drops any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      halted_q     <= 1'b0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= 32'h0;
      d_valid_q    <= 1'b0;
      d_rdata_q    <= 32'h0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      halted_q     <= halted_d;
      if_valid_q   <= if_valid_d;
      if_rdata_q   <= if_rdata_d;
      d_valid_q    <= d_valid_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign halted   = halted_q;
  assign if_valid = if_valid_q;
  assign if_rdata = if_rdata_q;
  assign d_valid  = d_valid_q;
  assign d_rdata  = d_rdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_if_q, stat_if_d;
  logic [15:0] stat_d_q, stat_d_d;
  logic [15:0] stat_conf_q, stat_conf_d;

  // Counter increments: grants per requester and cycles with live contention.
  always_comb begin
    stat_if_d   = stat_if_q + {15'h0, if_gnt};
    stat_d_d    = stat_d_q + {15'h0, d_gnt};
    stat_conf_d = stat_conf_q + {15'h0, (if_live & d_req)};
  end

  // Wrapping performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_if_q   <= 16'h0;
      stat_d_q    <= 16'h0;
      stat_conf_q <= 16'h0;
    end else begin
      stat_if_q   <= stat_if_d;
      stat_d_q    <= stat_d_d;
      stat_conf_q <= stat_conf_d;
    end
  end

  assign stat_if   = stat_if_q;
  assign stat_d    = stat_d_q;
  assign stat_conf = stat_conf_q;
`else
  assign stat_if   = 16'h0;
  assign stat_d    = 16'h0;
  assign stat_conf = 16'h0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [11:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        if_stall;
  logic        d_stall;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        halted;
  logic [15:0] stat_if;
  logic [15:0] stat_d;
  logic [15:0] stat_conf;

  logic [31:0] mem [0:1023];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];

  mem_port_arbiter #(.ADDR_W(12), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .if_stall(if_stall), .d_stall(d_stall),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .halted(halted),
    .stat_if(stat_if), .stat_d(stat_d), .stat_conf(stat_conf)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_if_stall;
    logic        e_d_stall;
    logic        e_rd;
    logic        e_wr;
    logic [11:0] e_addr;
    logic        e_ifv;
    logic        e_dv;
    logic        chk_ifr;
    logic [31:0] e_ifr;
    logic        chk_dr;
    logic [31:0] e_dr;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory commits a granted store once per cycle, after that cycle's checks.
  task automatic commit();
    if (mem_write) mem[mem_addr[11:2]] = mem_wdata;
  endtask

  // Reference model state for the random phase.
  int          m_den;
  bit          m_halt;
  bit          e_ifv, e_dv;
  logic [31:0] e_ifr, e_dr;
  bit          p_if_stall, p_d_stall;

  initial begin
    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_funct3 = 3'b010;
    d_addr = 0; d_wdata = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'h00500093; mem[1] = 32'h00100113; mem[2] = 32'h002081B3;
    mem[8] = 32'h00100073; mem[9] = 32'h00000073;

    //                if  ifaddr d  we daddr     dwdata        ifs ds rd wr addr     ifv dv cir ifr           cdr dr
    tbl[0]  = '{1, 32'h0, 0, 0, 32'h0,   32'h0,        0, 0, 1, 0, 12'h000, 0, 0, 0, 32'h0,        0, 32'h0};
    tbl[1]  = '{1, 32'h4, 0, 0, 32'h0,   32'h0,        0, 0, 1, 0, 12'h004, 1, 0, 1, 32'h00500093, 0, 32'h0};
    tbl[2]  = '{1, 32'h8, 0, 0, 32'h0,   32'h0,        0, 0, 1, 0, 12'h008, 1, 0, 1, 32'h00100113, 0, 32'h0};
    tbl[3]  = '{0, 32'h0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 1, 12'h100, 1, 0, 1, 32'h002081B3, 0, 32'h0};
    tbl[4]  = '{0, 32'h0, 1, 0, 32'h100, 32'h0,        0, 0, 1, 0, 12'h100, 0, 1, 0, 32'h0,        0, 32'h0};
    tbl[5]  = '{0, 32'h0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 12'h000, 0, 1, 0, 32'h0,        1, 32'hDEADBEEF};
    tbl[6]  = '{1, 32'h0, 1, 0, 32'h100, 32'h0,        1, 0, 1, 0, 12'h100, 0, 0, 0, 32'h0,        0, 32'h0};
    tbl[7]  = '{1, 32'h0, 1, 0, 32'h100, 32'h0,        1, 0, 1, 0, 12'h100, 0, 1, 0, 32'h0,        1, 32'hDEADBEEF};
    tbl[8]  = '{1, 32'h0, 1, 0, 32'h100, 32'h0,        1, 0, 1, 0, 12'h100, 0, 1, 0, 32'h0,        1, 32'hDEADBEEF};
    tbl[9]  = '{1, 32'h0, 1, 0, 32'h100, 32'h0,        0, 1, 1, 0, 12'h000, 0, 1, 0, 32'h0,        1, 32'hDEADBEEF};
    tbl[10] = '{1, 32'h0, 1, 0, 32'h100, 32'h0,        1, 0, 1, 0, 12'h100, 1, 0, 1, 32'h00500093, 0, 32'h0};
    tbl[11] = '{1, 32'h0, 1, 0, 32'h100, 32'h0,        1, 0, 1, 0, 12'h100, 0, 1, 0, 32'h0,        1, 32'hDEADBEEF};
    tbl[12] = '{1, 32'h0, 1, 0, 32'h100, 32'h0,        1, 0, 1, 0, 12'h100, 0, 1, 0, 32'h0,        1, 32'hDEADBEEF};
    tbl[13] = '{1, 32'h0, 1, 0, 32'h100, 32'h0,        0, 1, 1, 0, 12'h000, 0, 1, 0, 32'h0,        1, 32'hDEADBEEF};
    tbl[14] = '{0, 32'h0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 12'h000, 1, 0, 1, 32'h00500093, 0, 32'h0};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_stat_if", stat_if, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed table: fetch stream, store/load, starvation contention run.
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
      d_req = tbl[i].d_req; d_we = tbl[i].d_we; d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
      d_funct3 = 3'b010;
      @(negedge clk);
      chk($sformatf("t%0d_if_stall", i), if_stall, tbl[i].e_if_stall);
      chk($sformatf("t%0d_d_stall", i), d_stall, tbl[i].e_d_stall);
      chk($sformatf("t%0d_mem_read", i), mem_read, tbl[i].e_rd);
      chk($sformatf("t%0d_mem_write", i), mem_write, tbl[i].e_wr);
      chk($sformatf("t%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_if_valid", i), if_valid, tbl[i].e_ifv);
      chk($sformatf("t%0d_d_valid", i), d_valid, tbl[i].e_dv);
      if (tbl[i].chk_ifr) chk($sformatf("t%0d_if_rdata", i), if_rdata, tbl[i].e_ifr);
      if (tbl[i].chk_dr) chk($sformatf("t%0d_d_rdata", i), d_rdata, tbl[i].e_dr);
      commit();
    end
`ifdef MEM_ARB_STATS_EN
    chk("stat_if", stat_if, 5);
    chk("stat_d", stat_d, 8);
    chk("stat_conf", stat_conf, 8);
`else
    chk("stat_if", stat_if, 0);
    chk("stat_d", stat_d, 0);
    chk("stat_conf", stat_conf, 0);
`endif

    // Halt: ebreak does not halt, ecall does, data is still served afterwards.
    @(posedge clk); #1 if_req = 1; if_addr = 32'h20;
    @(negedge clk); chk("h_fetch_stall", if_stall, 0); commit();
    @(posedge clk); #1 if_addr = 32'h24;
    @(negedge clk);
    chk("h_ebreak_word", if_rdata, 32'h00100073);
    chk("h_ebreak_nohalt", halted, 0);
    commit();
    @(posedge clk); #1 if_addr = 32'h28;
    @(negedge clk);
    chk("h_ecall_valid", if_valid, 1);
    chk("h_ecall_word", if_rdata, 32'h00000073);
    chk("h_halted", halted, 1);
    chk("h_if_stall", if_stall, 1);
    chk("h_no_read", mem_read, 0);
    commit();
    @(posedge clk); #1 d_req = 1; d_we = 0; d_addr = 32'h100;
    @(negedge clk);
    chk("h_no_if_valid", if_valid, 0);
    chk("h_d_nostall", d_stall, 0);
    chk("h_d_addr", mem_addr, 12'h100);
    commit();
    @(posedge clk); #1 d_req = 0;
    @(negedge clk);
    chk("h_d_valid", d_valid, 1);
    chk("h_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("h_still_halted", halted, 1);
    commit();

    // Reset in the middle of a store grant.
    @(posedge clk); #1 if_req = 0; d_req = 1; d_we = 1; d_addr = 32'h104; d_wdata = 32'h12345678;
    @(negedge clk);
    chk("r_write_pre", mem_write, 1);
    #1 rst = 1'b1;
    #1;
    chk("r_write", mem_write, 0);
    chk("r_addr", mem_addr, 0);
    chk("r_wdata", mem_wdata, 0);
    chk("r_d_stall", d_stall, 0);
    chk("r_halted", halted, 0);
    chk("r_d_rdata", d_rdata, 0);
    chk("r_if_valid", if_valid, 0);
    chk("r_stat_d", stat_d, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0; d_req = 0; d_we = 0;
    @(negedge clk);
    chk("r_no_dvalid", d_valid, 0);
    chk("r_mem_untouched", mem[65], 0);

    // Randomized run against the behavioural model.
    for (int i = 0; i < 1023; i++) mem[i] = $urandom & ~32'h10;
    mem[1023] = 32'h00000073;
    m_den = 0; m_halt = 0; e_ifv = 0; e_dv = 0; e_ifr = 0; e_dr = 0;
    p_if_stall = 0; p_d_stall = 0;
    for (int c = 0; c < 1500; c++) begin
      bit live, prio, dg, fg;
      logic [11:0] ea;
      @(posedge clk); #1;
      if (!p_if_stall) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = 32'($urandom_range(0, 1023)) << 2;
      end
      if (!p_d_stall) begin
        d_req    = ($urandom_range(0, 99) < 50);
        d_we     = $urandom_range(0, 1) == 1;
        d_funct3 = 3'($urandom_range(0, 7));
        d_addr   = 32'($urandom_range(512, 1022)) << 2;
        d_wdata  = $urandom & ~32'h10;
      end
      @(negedge clk);
      live = if_req && !m_halt;
      prio = (m_den >= LIMIT);
      dg   = d_req && !(prio && live);
      fg   = live && !dg;
      ea   = dg ? d_addr[11:0] : (fg ? if_addr[11:0] : 12'h0);
      chk("rnd_if_stall", if_stall, if_req && !fg);
      chk("rnd_d_stall", d_stall, d_req && !dg);
      chk("rnd_mem_addr", mem_addr, ea);
      chk("rnd_mem_read", mem_read, fg || (dg && !d_we));
      chk("rnd_mem_write", mem_write, dg && d_we);
      chk("rnd_mem_funct3", mem_funct3, dg ? d_funct3 : (fg ? 3'b010 : 3'b000));
      chk("rnd_mem_wdata", mem_wdata, dg ? d_wdata : 32'h0);
      chk("rnd_if_valid", if_valid, e_ifv);
      chk("rnd_d_valid", d_valid, e_dv);
      chk("rnd_if_rdata", if_rdata, e_ifr);
      chk("rnd_d_rdata", d_rdata, e_dr);
      chk("rnd_halted", halted, m_halt);
      e_ifv = fg;
      e_dv  = dg;
      if (fg) begin
        e_ifr = mem[if_addr[11:2]];
        if (e_ifr[6:2] == 5'b11100 && !e_ifr[20]) m_halt = 1;
      end
      if (dg && !d_we) e_dr = mem[d_addr[11:2]];
      if (fg || !if_req) m_den = 0;
      else if (live) m_den++;
      p_if_stall = if_req && !fg;
      p_d_stall  = d_req && !dg;
      commit();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
